robo_seguidor: RTL
==================

# robo_seguidor

Left-hand wall-follower controller for the maze robot. It sits beside the 20x20 map/sensor block. It drives that block's `acao` (move) and `orientacao` (heading) inputs and reads back its `head`/`left` wall sensors. It sequences sense–decide–act cycles until the robot reaches a goal cell, exceeds a step budget, or is boxed in.

## Interface
- `START_ROW`, default 1: initial row of the internal position copy.
- `START_COL`, default 1: initial column of the internal position copy.
- `GOAL_ROW`, default 18: goal row.
- `GOAL_COL`, default 18: goal column.
- `STEP_W`, default 10: width of the step counter.
- `MAX_STEPS`, default 1023: step budget, must be < 2^STEP_W.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request to run; ignored while busy.
- `head`  in  1  wall ahead, from the map block.
- `left`  in  1  wall on left, from the map block.
- `acao`  out  3  move command to the map block: 001 N (row-1), 010 W (col-1), 011 S (row+1), 100 E (col+1), 000 none.
- `orientacao`  out  3  heading to the map block: 001 N, 010 W, 011 E, 100 S. Never 000.
- `busy`  out  1  high in SETTLE/DECIDE.
- `done`  out  1  sticky, goal reached.
- `fail`  out  1  sticky, budget exhausted or trapped.
- `steps`  out  STEP_W  moves issued since last start.
- `pos_row`  out  8  tracked robot row.
- `pos_col`  out  8  tracked robot column.

## Operation
- States:
  - IDLE: no run in progress.
  - SETTLE: 2-cycle wait so map sensors reflect the last command.
  - DECIDE: 1 cycle; samples `head`/`left`.
  - DONE, FAIL: terminal until the next `start`.
- Heading functions:
  - `left_of`: N→W, W→S, S→E, E→N.
  - `right_of`: N→E, E→S, S→W, W→N.
  - `dir_to_acao`: N→001, W→010, S→011, E→100. The action and orientation codes differ for S/E; always convert through this function.
- IDLE/DONE/FAIL + `start`:
  - clear `steps`, spin counter, `done`, `fail`.
  - keep position and heading; the map block's position is not resettable.
  - go to SETTLE.
- DECIDE priority, first match wins:
  1. pos == (GOAL_ROW, GOAL_COL) → DONE.
  2. `steps` == MAX_STEPS → FAIL.
  3. `left`=0 → `orientacao` <= `left_of`(o); `acao` <= `dir_to_acao`(`left_of`(o)); update position, steps+1, spin<=0 → SETTLE.
  4. `head`=0 → `acao` <= `dir_to_acao`(o); update position, steps+1, spin<=0 → SETTLE.
  5. Otherwise, if spin==3 → FAIL with no turn. Else `orientacao` <= `right_of`(o), spin+1 → SETTLE.
- `acao` is a single-cycle pulse. It is forced to 000 in every cycle except the one immediately after a moving DECIDE.
- Position arithmetic: 8-bit unsigned, wraps modulo 256, no clamping. The map block owns bounds handling.
- `done` and `fail` are mutually exclusive and hold until `start` or `reset`.

## Timing
- Reset values:
  - state IDLE, `acao`=000, `orientacao`=001.
  - `busy`=`done`=`fail`=0, `steps`=0.
  - `pos_row`=START_ROW, `pos_col`=START_COL, spin=0.
- Start sampled at edge E:
  - DECIDE samples sensors at edge E+3.
  - Commands and position change after E+3.
  - Following decisions at E+6, E+9, … (3-cycle period).
- `done`/`fail` assert after the deciding edge; `busy` drops in the same cycle.
- Reset mid-run: immediate return to reset values, including any in-flight `acao`.
- `start` coincident with DECIDE is ignored.

## Structure
- Package `robo_pkg` holds:
  - orientation constants (`OR_N`, `OR_W`, `OR_E`, `OR_S`).
  - action constants (`AC_NONE`, `AC_N`, `AC_W`, `AC_S`, `AC_E`).
  - state enum.
  - functions `left_of`, `right_of`, `dir_to_acao`.
- Single module with no sub-module; the settle counter and spin counter are 2-bit locals.

## Test plan
- Reset, no start → `acao`=000, `orientacao`=001, `busy`=0, `steps`=0, pos=(1,1) for 20 cycles.
- START=(5,5), stub `left`=0, start at E → after E+3, `orientacao`=010 and `acao`=010 for exactly one cycle. pos=(5,4), `steps`=1, `busy`=1.
- START=(5,5), `left`=1, `head`=0 → `acao`=001 pulse, `orientacao` stays 001, pos=(4,5).
- `head`=`left`=1 constantly → `orientacao` goes 011, 100, 010 at E+3/E+6/E+9. `fail`=1 after E+12, `acao` never nonzero, `steps`=0.
- START=(5,5), GOAL=(5,4), `left`=0 → one move, then `done`=1 after E+6 with `steps`=1.
- Budget and reset:
  - MAX_STEPS=2, `head`=0, `left`=1 → two N pulses, `fail`=1 after E+9, pos=(3,5).
  - Repeat the run and assert `reset` at E+4 → all outputs return to reset values.
  - Full run on the real map block with Mapa.txt → `done`=1 at goal.

Source files
------------

// File: rtl/robo_pkg.sv
// Shared encodings and heading helpers for the left-hand wall-follower.
// Orientation and action codes differ for S/E, so moves always go through dir_to_acao.
package robo_pkg;

  localparam logic [2:0] OR_N = 3'b001;
  localparam logic [2:0] OR_W = 3'b010;
  localparam logic [2:0] OR_E = 3'b011;
  localparam logic [2:0] OR_S = 3'b100;

  localparam logic [2:0] AC_NONE = 3'b000;
  localparam logic [2:0] AC_N    = 3'b001;
  localparam logic [2:0] AC_W    = 3'b010;
  localparam logic [2:0] AC_S    = 3'b011;
  localparam logic [2:0] AC_E    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DECIDE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  function automatic logic [2:0] left_of(input logic [2:0] o);
    case (o)
      OR_N:    left_of = OR_W;
      OR_W:    left_of = OR_S;
      OR_S:    left_of = OR_E;
      OR_E:    left_of = OR_N;
      default: left_of = OR_N;
    endcase
  endfunction

  function automatic logic [2:0] right_of(input logic [2:0] o);
    case (o)
      OR_N:    right_of = OR_E;
      OR_E:    right_of = OR_S;
      OR_S:    right_of = OR_W;
      OR_W:    right_of = OR_N;
      default: right_of = OR_N;
    endcase
  endfunction

  function automatic logic [2:0] dir_to_acao(input logic [2:0] o);
    case (o)
      OR_N:    dir_to_acao = AC_N;
      OR_W:    dir_to_acao = AC_W;
      OR_S:    dir_to_acao = AC_S;
      OR_E:    dir_to_acao = AC_E;
      default: dir_to_acao = AC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/robo_seguidor.sv
// Left-hand wall-follower: sense-decide-act sequencer driving the map block,
// with a tracked position copy, step budget and trapped detection.
module robo_seguidor
  import robo_pkg::*;
#(
  parameter int START_ROW = 1,
  parameter int START_COL = 1,
  parameter int GOAL_ROW  = 18,
  parameter int GOAL_COL  = 18,
  parameter int STEP_W    = 10,
  parameter int MAX_STEPS = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              head,
  input  logic              left,
  output logic [2:0]        acao,
  output logic [2:0]        orientacao,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] steps,
  output logic [7:0]        pos_row,
  output logic [7:0]        pos_col
);

  localparam logic [7:0]        START_ROW_C = 8'(START_ROW);
  localparam logic [7:0]        START_COL_C = 8'(START_COL);
  localparam logic [7:0]        GOAL_ROW_C  = 8'(GOAL_ROW);
  localparam logic [7:0]        GOAL_COL_C  = 8'(GOAL_COL);
  localparam logic [STEP_W-1:0] MAX_C       = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  state_t            state_r;
  logic [1:0]        settle_r;
  logic [1:0]        spin_r;
  logic [2:0]        acao_r;
  logic [2:0]        orient_r;
  logic              busy_r;
  logic              done_r;
  logic              fail_r;
  logic [STEP_W-1:0] steps_r;
  logic [7:0]        row_r;
  logic [7:0]        col_r;

  logic [2:0]        move_dir_s;
  logic [7:0]        next_row_s;
  logic [7:0]        next_col_s;

  // Direction of a move this DECIDE (left turn wins) and the resulting cell.
  always_comb begin
    move_dir_s = orient_r;
    next_row_s = row_r;
    next_col_s = col_r;
    if (!left) begin
      move_dir_s = left_of(orient_r);
    end else begin
      move_dir_s = orient_r;
    end
    case (move_dir_s)
      OR_N:    next_row_s = row_r - 8'd1;
      OR_S:    next_row_s = row_r + 8'd1;
      OR_W:    next_col_s = col_r - 8'd1;
      OR_E:    next_col_s = col_r + 8'd1;
      default: next_row_s = row_r;
    endcase
  end

  // Controller FSM with all outputs registered; acao defaults to a no-move each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      settle_r <= 2'd0;
      spin_r   <= 2'd0;
      acao_r   <= AC_NONE;
      orient_r <= OR_N;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      fail_r   <= 1'b0;
      steps_r  <= '0;
      row_r    <= START_ROW_C;
      col_r    <= START_COL_C;
    end else begin
      acao_r <= AC_NONE;
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            steps_r  <= '0;
            spin_r   <= 2'd0;
            settle_r <= 2'd0;
            done_r   <= 1'b0;
            fail_r   <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_r == 2'd1) begin
            settle_r <= 2'd0;
            state_r  <= ST_DECIDE;
          end else begin
            settle_r <= settle_r + 2'd1;
          end
        end
        ST_DECIDE: begin
          if (row_r == GOAL_ROW_C && col_r == GOAL_COL_C) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else if (steps_r == MAX_C) begin
            fail_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_FAIL;
          end else if (!left || !head) begin
            orient_r <= move_dir_s;
            acao_r   <= dir_to_acao(move_dir_s);
            row_r    <= next_row_s;
            col_r    <= next_col_s;
            steps_r  <= steps_r + STEP_ONE;
            spin_r   <= 2'd0;
            state_r  <= ST_SETTLE;
          end else if (spin_r == 2'd3) begin
            // Every heading tried from this cell without an opening: boxed in.
            fail_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_FAIL;
          end else begin
            orient_r <= right_of(orient_r);
            spin_r   <= spin_r + 2'd1;
            state_r  <= ST_SETTLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign acao       = acao_r;
  assign orientacao = orient_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;
  assign steps      = steps_r;
  assign pos_row    = row_r;
  assign pos_col    = col_r;

endmodule
